// File: rtl/swc_fabric_sink.sv
// Fabric sink for one swc_core source port: acks Wishbone fabric words, buffers them in a
// first-word-fall-through FIFO and presents frames as a valid/dreq beat stream with SOF/EOF.
module swc_fabric_sink #(
    parameter int unsigned g_fifo_depth      = 16,
    parameter int unsigned g_stall_threshold = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] snk_dat_i,
    input  logic [1:0]  snk_adr_i,
    input  logic [1:0]  snk_sel_i,
    input  logic        snk_cyc_i,
    input  logic        snk_stb_i,
    input  logic        snk_we_i,
    output logic        snk_stall_o,
    output logic        snk_ack_o,
    output logic        snk_err_o,
    output logic        snk_rty_o,
    output logic [15:0] rx_data_o,
    output logic [1:0]  rx_adr_o,
    output logic        rx_bytesel_o,
    output logic        rx_sof_o,
    output logic        rx_eof_o,
    output logic        rx_error_o,
    output logic        rx_valid_o,
    input  logic        rx_dreq_i,
    output logic [15:0] frame_cnt_o
);

    localparam int unsigned AddrW  = $clog2(g_fifo_depth);
    localparam int unsigned CntW   = AddrW + 1;
    localparam int unsigned EntryW = 22;
    localparam int unsigned StallAt = g_fifo_depth - g_stall_threshold;

    typedef enum logic [1:0] {StIdle, StRecv, StEndf} state_e;

    state_e            state_q;
    logic              cyc_q;
    logic              pushed_q;
    logic              frame_err_q;
    logic              stall_q;
    logic              ack_q;
    logic              err_q;
    logic [15:0]       frame_cnt_q;
    logic [AddrW-1:0]  wr_ptr_q;
    logic [AddrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [CntW-1:0]   count_d;
    logic [EntryW-1:0] mem_q [g_fifo_depth];

    logic              xfer;
    logic              start;
    logic              in_frame;
    logic              frame_end;
    logic              fifo_full;
    logic              fifo_empty;
    logic              data_push;
    logic              eof_push;
    logic              push;
    logic              pop;
    logic              word_bad;
    logic              status_err;
    logic              sof;
    logic [EntryW-1:0] push_entry;
    logic [EntryW-1:0] head;

    assign xfer       = snk_cyc_i & snk_stb_i & ~stall_q;
    // cyc_q resets high so a cyc already asserted at reset release never opens a frame.
    assign start      = snk_cyc_i & ~cyc_q & (state_q != StRecv);
    assign in_frame   = start | ((state_q == StRecv) & snk_cyc_i);
    assign frame_end  = (state_q == StRecv) & ~snk_cyc_i;
    assign fifo_full  = count_q == CntW'(g_fifo_depth);
    assign fifo_empty = count_q == '0;

    assign data_push  = in_frame & xfer & snk_we_i & ~fifo_full;
    assign word_bad   = in_frame & xfer & (~snk_we_i | fifo_full);
    assign status_err = data_push & (snk_adr_i == 2'd2) & snk_dat_i[1];
    assign eof_push   = frame_end & pushed_q & ~fifo_full;
    assign push       = data_push | eof_push;
    assign pop        = ~fifo_empty & rx_dreq_i;
    assign sof        = start | ~pushed_q;

    // Entry layout: {eof, error, sof, bytesel, adr[1:0], dat[15:0]}.
    always_comb begin
        push_entry = '0;
        if (eof_push) begin
            push_entry[21] = 1'b1;
            push_entry[20] = frame_err_q;
        end else begin
            push_entry = {2'b00, sof, (snk_sel_i == 2'b10), snk_adr_i, snk_dat_i};
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            cyc_q       <= 1'b1;
            pushed_q    <= 1'b0;
            frame_err_q <= 1'b0;
            stall_q     <= 1'b1;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            cyc_q   <= snk_cyc_i;
            stall_q <= count_d >= CntW'(StallAt);
            ack_q   <= xfer & ~word_bad;
            err_q   <= word_bad;
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AddrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AddrW'(1);
            end
            if (start) begin
                pushed_q    <= data_push;
                frame_err_q <= word_bad | status_err;
            end else begin
                pushed_q    <= pushed_q | data_push;
                frame_err_q <= frame_err_q | word_bad | status_err;
            end
            if (eof_push) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            case (state_q)
                StIdle:  if (start) state_q <= StRecv;
                StRecv:  if (!snk_cyc_i) state_q <= StEndf;
                StEndf:  state_q <= start ? StRecv : StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign head = mem_q[rd_ptr_q];

    assign snk_stall_o  = stall_q;
    assign snk_ack_o    = ack_q;
    assign snk_err_o    = err_q;
    assign snk_rty_o    = 1'b0;
    assign frame_cnt_o  = frame_cnt_q;
    assign rx_valid_o   = ~fifo_empty;
    assign rx_eof_o     = rx_valid_o & head[21];
    assign rx_error_o   = rx_valid_o & head[20];
    assign rx_sof_o     = rx_valid_o & head[19];
    assign rx_bytesel_o = rx_valid_o & head[18];
    assign rx_adr_o     = rx_valid_o ? head[17:16] : 2'd0;
    assign rx_data_o    = rx_valid_o ? head[15:0] : 16'd0;

endmodule
